// File: rtl/seven_seg_scan_decoder_if.sv
// Display-bus pins plus the decoded-frame valid/ready stream.
// SEVSEG_BLANK_EN adds the per-digit out_blank flags.
interface seven_seg_scan_decoder_if #(parameter int DIGITS = 4);
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] out_value;
    logic [DIGITS-1:0]   out_err;
`ifdef SEVSEG_BLANK_EN
    logic [DIGITS-1:0]   out_blank;

    modport master (input an, seg, out_ready,
                    output out_valid, out_value, out_err, out_blank);
    modport slave  (output an, seg, out_ready,
                    input out_valid, out_value, out_err, out_blank);
`else
    modport master (input an, seg, out_ready,
                    output out_valid, out_value, out_err);
    modport slave  (output an, seg, out_ready,
                    input out_valid, out_value, out_err);
`endif
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Passive reader of a multiplexed active-low 7-seg bus: debounce each digit,
// decode to hex, emit full frames. SEVSEG_BLANK_EN makes 1111111 a legal blank.
module seven_seg_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic                        clk,
    input logic                        reset,
    seven_seg_scan_decoder_if.master   bus
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int IW = $clog2(DIGITS);
    // One equal comparison short of STABLE_CYCLES-1: capture on the edge that reaches it
    localparam logic [CW-1:0] CAP_AT = CW'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HELD} state_t;

    logic [DIGITS-1:0]       r_an_q, r_an_p;
    logic [6:0]              r_seg_q, r_seg_p;
    state_t                  r_state, w_nstate;
    logic [CW-1:0]           r_cnt, w_ncnt;
    logic                    w_cap, w_same, w_onehot, w_load;
    logic [IW-1:0]           w_sel;
    logic [5:0]              w_dec;
    logic [DIGITS-1:0]       r_seen, w_seen_nxt;
    logic [DIGITS-1:0][3:0]  r_sh_val, r_out_val;
    logic [DIGITS-1:0]       r_sh_err, r_out_err;
    logic                    r_out_valid;
`ifdef SEVSEG_BLANK_EN
    logic [DIGITS-1:0]       r_sh_blank, r_out_blank;
`endif

    // Returns {blank, err, nibble}
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = 6'h00;  7'b1111001: decode = 6'h01;
            7'b0100100: decode = 6'h02;  7'b0110000: decode = 6'h03;
            7'b0011001: decode = 6'h04;  7'b0010010: decode = 6'h05;
            7'b0000010: decode = 6'h06;  7'b1111000: decode = 6'h07;
            7'b0000000: decode = 6'h08;  7'b0010000: decode = 6'h09;
            7'b0001000: decode = 6'h0A;  7'b0000011: decode = 6'h0B;
            7'b1000110: decode = 6'h0C;  7'b0100001: decode = 6'h0D;
            7'b0000110: decode = 6'h0E;  7'b0001110: decode = 6'h0F;
`ifdef SEVSEG_BLANK_EN
            7'b1111111: decode = 6'b100000;
`endif
            default:    decode = 6'b010000;
        endcase
    endfunction

    assign w_same   = (r_an_q == r_an_p) && (r_seg_q == r_seg_p);
    assign w_onehot = $onehot(~r_an_q);
    assign w_dec    = decode(r_seg_q);
    assign w_load   = (&r_seen) && (!r_out_valid || bus.out_ready);

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < DIGITS; i++)
            if (!r_an_q[i]) w_sel = IW'(i);
    end

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = '0;
        w_cap    = 1'b0;
        case (r_state)
            S_IDLE:  if (w_onehot) w_nstate = S_COUNT;
            S_COUNT: begin
                if (!w_same)              w_nstate = w_onehot ? S_COUNT : S_IDLE;
                else if (r_cnt == CAP_AT) begin
                    w_cap    = 1'b1;
                    w_nstate = S_HELD;
                end else                  w_ncnt = r_cnt + CW'(1);
            end
            S_HELD:  if (!w_same) w_nstate = w_onehot ? S_COUNT : S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    // A capture on the loading edge belongs to the next frame
    always_comb begin
        w_seen_nxt = w_load ? '0 : r_seen;
        if (w_cap) w_seen_nxt[w_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an_q      <= '1;
            r_an_p      <= '1;
            r_seg_q     <= '1;
            r_seg_p     <= '1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_seen      <= '0;
            r_sh_val    <= '0;
            r_sh_err    <= '0;
            r_out_val   <= '0;
            r_out_err   <= '0;
            r_out_valid <= 1'b0;
`ifdef SEVSEG_BLANK_EN
            r_sh_blank  <= '0;
            r_out_blank <= '0;
`endif
        end else begin
            r_an_q  <= bus.an;
            r_seg_q <= bus.seg;
            r_an_p  <= r_an_q;
            r_seg_p <= r_seg_q;
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_seen  <= w_seen_nxt;
            if (w_cap) begin
                r_sh_val[w_sel]   <= w_dec[3:0];
                r_sh_err[w_sel]   <= w_dec[4];
`ifdef SEVSEG_BLANK_EN
                r_sh_blank[w_sel] <= w_dec[5];
`endif
            end
            if (w_load) begin
                r_out_val   <= r_sh_val;
                r_out_err   <= r_sh_err;
                r_out_valid <= 1'b1;
`ifdef SEVSEG_BLANK_EN
                r_out_blank <= r_sh_blank;
`endif
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_value = r_out_val;
    assign bus.out_err   = r_out_err;
`ifdef SEVSEG_BLANK_EN
    assign bus.out_blank = r_out_blank;
`endif
endmodule
